// File: rtl/rom_arbiter_pkg.sv
// rom_arb_pkg: shared FSM states, line geometry and arbitration winner encoding
package rom_arb_pkg;
  localparam int LINE_WORDS = 8;
  localparam int OFF_W = $clog2(LINE_WORDS);
  typedef enum logic [2:0] {S_IDLE, S_FILL, S_DRAIN, S_DATA, S_DATA_RSP} state_e;
  typedef enum logic {W_DATA = 1'b0, W_FILL = 1'b1} winner_e;
endpackage

// File: rtl/rom_arbiter_if.sv
// rom_arbiter_if: requester/ROM bundle; master drives requests and rom_q, slave is the arbiter
interface rom_arbiter_if #(parameter int ADDR_W = 8, parameter int DATA_W = 8);
  import rom_arb_pkg::*;
  logic              fill_req;
  logic [ADDR_W-1:0] fill_base;
  logic              fill_ack;
  logic              fill_wren;
  logic [OFF_W-1:0]  fill_offset;
  logic [DATA_W-1:0] fill_data;
  logic              fill_done;
  logic              dat_req;
  logic [ADDR_W-1:0] dat_addr;
  logic              dat_gnt;
  logic              dat_valid;
  logic [DATA_W-1:0] dat_data;
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_q;
  logic              busy;
  modport master (
    output fill_req, fill_base, dat_req, dat_addr, rom_q,
    input  fill_ack, fill_wren, fill_offset, fill_data, fill_done,
    input  dat_gnt, dat_valid, dat_data, rom_addr, busy
  );
  modport slave (
    input  fill_req, fill_base, dat_req, dat_addr, rom_q,
    output fill_ack, fill_wren, fill_offset, fill_data, fill_done,
    output dat_gnt, dat_valid, dat_data, rom_addr, busy
  );
endinterface

// File: rtl/rom_burst_gen.sv
// rom_burst_gen: line-fill issue counter, in-line address formation, delayed wren/offset
// Ports: start_i loads line_i and clears the counter; run_i advances it (FILL state);
// addr_o is the next address to register; first_o/last_o flag counter 0/7; wren_o/off_o trail issue by one cycle.
module rom_burst_gen import rom_arb_pkg::*; #(parameter int ADDR_W = 8) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start_i,
  input  logic                    run_i,
  input  logic [ADDR_W-OFF_W-1:0] line_i,
  output logic [ADDR_W-1:0]       addr_o,
  output logic                    first_o,
  output logic                    last_o,
  output logic                    wren_o,
  output logic [OFF_W-1:0]        off_o
);
  logic [ADDR_W-OFF_W-1:0] line_q;
  logic [OFF_W-1:0] cnt_q, cnt_n, off_q;
  logic wren_q;
  // Only the offset bits count, so the line part never changes within a burst.
  assign cnt_n = cnt_q + 1'b1;
  assign addr_o = start_i ? {line_i, {OFF_W{1'b0}}} : {line_q, cnt_n};
  assign first_o = cnt_q == '0;
  assign last_o = cnt_q == OFF_W'(LINE_WORDS - 1);
  assign wren_o = wren_q;
  assign off_o = off_q;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      line_q <= '0;
      cnt_q <= '0;
      off_q <= '0;
      wren_q <= 1'b0;
    end else begin
      line_q <= start_i ? line_i : line_q;
      cnt_q <= start_i ? '0 : run_i ? cnt_n : cnt_q;
      off_q <= run_i ? cnt_q : off_q;
      wren_q <= run_i;
    end
endmodule

// File: rtl/rom_arbiter.sv
// rom_arbiter: shares one 1-cycle-latency ROM between 8-word cache line fills and data reads
// Ports: clk, reset (async active-high), bus (rom_arbiter_if.slave: fill/data handshakes, rom_addr/rom_q, busy).
module rom_arbiter import rom_arb_pkg::*; #(parameter int ADDR_W = 8, parameter int DATA_W = 8) (
  input logic          clk,
  input logic          reset,
  rom_arbiter_if.slave bus
);
  state_e state_q, state_d;
  winner_e last_q, last_d;
  logic [ADDR_W-1:0] rom_addr_q, rom_addr_d, burst_addr;
  logic [DATA_W-1:0] dat_data_q;
  logic dat_valid_q, first, last, pick_fill, start;
  // Under contention the requester that did not win last time gets the ROM.
  assign pick_fill = bus.fill_req && (!bus.dat_req || last_q == W_DATA);
  assign start = state_q == S_IDLE && pick_fill;
  rom_burst_gen #(.ADDR_W(ADDR_W)) u_burst (
    .clk(clk), .reset(reset), .start_i(start), .run_i(state_q == S_FILL),
    .line_i(bus.fill_base[ADDR_W-1:OFF_W]), .addr_o(burst_addr),
    .first_o(first), .last_o(last), .wren_o(bus.fill_wren), .off_o(bus.fill_offset)
  );
  always_comb begin
    state_d = state_q;
    last_d = last_q;
    rom_addr_d = rom_addr_q;
    case (state_q)
      S_IDLE: begin
        state_d = pick_fill ? S_FILL : bus.dat_req ? S_DATA : S_IDLE;
        rom_addr_d = pick_fill ? burst_addr : bus.dat_req ? bus.dat_addr : rom_addr_q;
        last_d = (bus.fill_req && bus.dat_req) ? (pick_fill ? W_FILL : W_DATA) : last_q;
      end
      // Hold the final in-line address through DRAIN so no wrapped address is issued.
      S_FILL: begin
        state_d = last ? S_DRAIN : S_FILL;
        rom_addr_d = last ? rom_addr_q : burst_addr;
      end
      S_DATA: state_d = S_DATA_RSP;
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q <= S_IDLE;
      last_q <= W_DATA;
      rom_addr_q <= '0;
      dat_data_q <= '0;
      dat_valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q <= last_d;
      rom_addr_q <= rom_addr_d;
      dat_data_q <= state_q == S_DATA_RSP ? bus.rom_q : dat_data_q;
      dat_valid_q <= state_q == S_DATA_RSP;
    end
  assign bus.fill_ack = state_q == S_FILL && first;
  assign bus.fill_done = state_q == S_DRAIN;
  assign bus.fill_data = bus.rom_q;
  assign bus.dat_gnt = state_q == S_DATA;
  assign bus.dat_valid = dat_valid_q;
  assign bus.dat_data = dat_data_q;
  assign bus.rom_addr = rom_addr_q;
  assign bus.busy = state_q != S_IDLE;
endmodule

// File: tb/tb_rom_arbiter.sv
// tb_rom_arbiter: directed stimulus with scoreboard queues for fill writes and data reads
module tb_rom_arbiter;
  logic clk, reset;
  int tests = 0, fails = 0;
  logic [10:0] fill_q[$];
  logic [7:0] dat_q[$];
  rom_arbiter_if bus ();
  rom_arbiter dut (.clk(clk), .reset(reset), .bus(bus));
  function automatic logic [7:0] rom_val(input logic [7:0] a);
    return a == 8'hA3 ? 8'h5C : ({a[3:0], a[7:4]} ^ 8'hC3) + 8'h07;
  endfunction
  always_ff @(posedge clk) bus.rom_q <= rom_val(bus.rom_addr);
  initial clk = 0;
  always #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask
  task automatic step();
    logic [10:0] e;
    @(posedge clk);
    #1;
    if (bus.fill_wren) begin
      if (fill_q.size() == 0) chk("fill_wren_unexpected", bus.fill_wren, 0);
      else begin
        e = fill_q.pop_front();
        chk("fill_offset", bus.fill_offset, e[10:8]);
        chk("fill_data", bus.fill_data, e[7:0]);
      end
    end
    if (bus.dat_valid) begin
      if (dat_q.size() == 0) chk("dat_valid_unexpected", bus.dat_valid, 0);
      else chk("dat_data", bus.dat_data, dat_q.pop_front());
    end
  endtask
  task automatic do_fill(input logic [7:0] b, input int drop_at);
    logic [7:0] l;
    l = {b[7:3], 3'b000};
    bus.fill_req = 1;
    bus.fill_base = b;
    for (int i = 0; i < 8; i++) fill_q.push_back({3'(i), rom_val(l | 8'(i))});
    for (int c = 1; c <= 9; c++) begin
      step();
      chk("fill_ack", bus.fill_ack, c == 1);
      chk("fill_done", bus.fill_done, c == 9);
      chk("fill_rom_addr", bus.rom_addr, l | 8'(c == 9 ? 7 : c - 1));
      chk("fill_busy", bus.busy, 1);
      if (c == drop_at) begin
        bus.fill_req = 0;
        if (c < 9) bus.fill_base = 8'h10;
      end
    end
    step();
    chk("fill_end_busy", bus.busy, 0);
    chk("fill_end_addr", bus.rom_addr, l | 8'h07);
    chk("fill_q_left", fill_q.size(), 0);
  endtask
  task automatic do_dat(input logic [7:0] a);
    bus.dat_req = 1;
    bus.dat_addr = a;
    dat_q.push_back(rom_val(a));
    step();
    chk("dat_gnt", bus.dat_gnt, 1);
    chk("dat_rom_addr", bus.rom_addr, a);
    chk("dat_fill_ack", bus.fill_ack, 0);
    bus.dat_addr = 8'h00;
    step();
    chk("dat_gnt_pulse", bus.dat_gnt, 0);
    chk("dat_valid_early", bus.dat_valid, 0);
    step();
    chk("dat_valid", bus.dat_valid, 1);
    bus.dat_req = 0;
    step();
    chk("dat_valid_pulse", bus.dat_valid, 0);
    chk("dat_hold", bus.dat_data, rom_val(a));
    chk("dat_busy", bus.busy, 0);
  endtask
  initial begin
    reset = 1;
    bus.fill_req = 0;
    bus.fill_base = 0;
    bus.dat_req = 0;
    bus.dat_addr = 0;
    step();
    step();
    chk("rst_rom_addr", bus.rom_addr, 0);
    chk("rst_dat_data", bus.dat_data, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_pulses", {bus.fill_ack, bus.fill_wren, bus.fill_done, bus.dat_gnt, bus.dat_valid}, 0);
    reset = 0;
    step();
    chk("idle_busy", bus.busy, 0);
    do_fill(8'h2D, 9);
    do_dat(8'hA3);
    bus.dat_req = 1;
    bus.dat_addr = 8'h11;
    dat_q.push_back(rom_val(8'h11));
    do_fill(8'h50, -1);
    step();
    chk("cont1_dat_gnt", bus.dat_gnt, 1);
    chk("cont1_rom_addr", bus.rom_addr, 8'h11);
    chk("cont1_fill_ack", bus.fill_ack, 0);
    bus.fill_req = 0;
    step();
    step();
    chk("cont1_dat_valid", bus.dat_valid, 1);
    bus.dat_req = 0;
    step();
    chk("cont1_busy", bus.busy, 0);
    bus.dat_req = 1;
    bus.dat_addr = 8'h22;
    dat_q.push_back(rom_val(8'h22));
    do_fill(8'h60, 9);
    step();
    chk("cont2_dat_gnt", bus.dat_gnt, 1);
    chk("cont2_rom_addr", bus.rom_addr, 8'h22);
    step();
    step();
    chk("cont2_dat_valid", bus.dat_valid, 1);
    bus.dat_req = 0;
    step();
    chk("cont2_busy", bus.busy, 0);
    do_fill(8'hFF, 9);
    do_fill(8'h30, 3);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("mid_no_restart", {bus.busy, bus.fill_ack}, 0);
    end
    bus.fill_req = 1;
    bus.fill_base = 8'h40;
    for (int i = 0; i < 8; i++) fill_q.push_back({3'(i), rom_val(8'h40 | 8'(i))});
    repeat (5) step();
    chk("abort_busy_before", bus.busy, 1);
    reset = 1;
    #1;
    chk("abort_busy", bus.busy, 0);
    chk("abort_pulses", {bus.fill_ack, bus.fill_wren, bus.fill_done, bus.dat_gnt, bus.dat_valid}, 0);
    chk("abort_rom_addr", bus.rom_addr, 0);
    chk("abort_offset", bus.fill_offset, 0);
    chk("abort_dat_data", bus.dat_data, 0);
    bus.fill_req = 0;
    fill_q.delete();
    step();
    chk("abort_no_done", bus.fill_done, 0);
    step();
    reset = 0;
    step();
    chk("abort_idle", bus.busy, 0);
    do_fill(8'h40, 9);
    chk("end_fill_q", fill_q.size(), 0);
    chk("end_dat_q", dat_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
